// File: rtl/contador_secuenciador_if.sv
// Control/status bundle between the sequencer and its upstream controller.
// The slave modport is the sequencer side; master is the controller side.
interface contador_secuenciador_if;
  logic       start;
  logic [3:0] start_val;
  logic [3:0] stop_val;
  logic       abort;
  logic       load;
  logic       en;
  logic       oe;
  logic [3:0] d;
  logic [3:0] shadow;
  logic       busy;
  logic       done;

  modport master (
    output start, start_val, stop_val, abort,
    input  load, en, oe, d, shadow, busy, done
  );

  modport slave (
    input  start, start_val, stop_val, abort,
    output load, en, oe, d, shadow, busy, done
  );
endinterface

// File: rtl/contador_secuenciador.sv
// Sequencer driving LOAD/EN/OE of a 4-bit loadable up-counter, with a shadow copy of its value.
// Define CONTADOR_SECUENCIADOR_AUTORELOAD_EN to repeat load/count/show until abort or rst.
module contador_secuenciador #(
  parameter int unsigned PRESC   = 4,
  parameter int unsigned OE_HOLD = 3,
  parameter int unsigned PW      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  contador_secuenciador_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, SHOW} state_t;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(OE_HOLD - 1);
  localparam logic          EN_EVERY   = (PRESC == 1);

  state_t        state_q, state_n;
  logic          load_q, load_n;
  logic          en_q, en_n;
  logic          oe_q, oe_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [3:0]    d_q, d_n;
  logic [3:0]    stop_q, stop_n;
  logic [3:0]    shadow_q, shadow_n;
  logic [3:0]    shadow_inc;
  logic [PW-1:0] presc_q, presc_n;
  logic [PW-1:0] hold_q, hold_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      stop_q   <= '0;
      shadow_q <= '0;
      presc_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_n;
      load_q   <= load_n;
      en_q     <= en_n;
      oe_q     <= oe_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      d_q      <= d_n;
      stop_q   <= stop_n;
      shadow_q <= shadow_n;
      presc_q  <= presc_n;
      hold_q   <= hold_n;
    end
  end

  // Outputs are registered, so each strobe is computed for the state being entered.
  always_comb begin
    state_n    = state_q;
    load_n     = 1'b0;
    en_n       = 1'b0;
    oe_n       = 1'b0;
    busy_n     = busy_q;
    done_n     = 1'b0;
    d_n        = d_q;
    stop_n     = stop_q;
    shadow_n   = shadow_q;
    presc_n    = presc_q;
    hold_n     = hold_q;
    shadow_inc = shadow_q + 4'd1;

    if (bus.abort && (state_q != IDLE)) begin
      state_n = IDLE;
      busy_n  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            d_n     = bus.start_val;
            stop_n  = bus.stop_val;
            state_n = LOAD;
            load_n  = 1'b1;
            busy_n  = 1'b1;
          end
        end
        LOAD: begin
          shadow_n = d_q;
          presc_n  = '0;
          if (d_q == stop_q) begin
            state_n = SHOW;
            oe_n    = 1'b1;
            hold_n  = '0;
          end else begin
            state_n = COUNT;
            en_n    = EN_EVERY;
          end
        end
        COUNT: begin
          if (en_q) begin
            shadow_n = shadow_inc;
            presc_n  = '0;
            if (shadow_inc == stop_q) begin
              state_n = SHOW;
              oe_n    = 1'b1;
              hold_n  = '0;
            end else begin
              en_n = EN_EVERY;
            end
          end else begin
            presc_n = presc_q + 1'b1;
            en_n    = (presc_n == PRESC_LAST);
          end
        end
        SHOW: begin
          if (hold_q == HOLD_LAST) begin
            done_n = 1'b1;
`ifdef CONTADOR_SECUENCIADOR_AUTORELOAD_EN
            state_n = LOAD;
            load_n  = 1'b1;
`else
            state_n = IDLE;
            busy_n  = 1'b0;
`endif
          end else begin
            oe_n   = 1'b1;
            hold_n = hold_q + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  assign bus.load   = load_q;
  assign bus.en     = en_q;
  assign bus.oe     = oe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.d      = d_q;
  assign bus.shadow = shadow_q;

endmodule

// File: tb/tb_contador_secuenciador.sv
// Bench for contador_secuenciador: two instances (PRESC=4 and PRESC=1) share start stimulus and
// are compared cycle by cycle against a trace model built from the load/count/show rules.
module tb_contador_secuenciador;

  typedef struct packed {
    logic       load;
    logic       en;
    logic       oe;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic [3:0] shadow;
  } exp_t;

`ifdef CONTADOR_SECUENCIADOR_AUTORELOAD_EN
  localparam int LOOPS = 2;
`else
  localparam int LOOPS = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  contador_secuenciador_if bus4();
  contador_secuenciador_if bus1();

  assign bus1.start     = bus4.start;
  assign bus1.start_val = bus4.start_val;
  assign bus1.stop_val  = bus4.stop_val;

  contador_secuenciador #(.PRESC(4), .OE_HOLD(3), .PW(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  contador_secuenciador #(.PRESC(1), .OE_HOLD(3), .PW(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  int   passes = 0;
  int   checks = 0;
  exp_t trace[$];
  exp_t q4[$], q1[$], obs4[$], obs1[$];
  int   eff_abort;
  logic [3:0] sh4 = '0, sh1 = '0;

  function automatic exp_t sample4();
    exp_t e;
    e.load = bus4.load; e.en = bus4.en; e.oe = bus4.oe; e.busy = bus4.busy;
    e.done = bus4.done; e.d = bus4.d; e.shadow = bus4.shadow;
    return e;
  endfunction

  function automatic exp_t sample1();
    exp_t e;
    e.load = bus1.load; e.en = bus1.en; e.oe = bus1.oe; e.busy = bus1.busy;
    e.done = bus1.done; e.d = bus1.d; e.shadow = bus1.shadow;
    return e;
  endfunction

  // Expected outputs per cycle, starting with the cycle right after the accepted start.
  function automatic void build(input int presc, input int hold, input logic [3:0] sv,
                                input logic [3:0] tv, input logic [3:0] sh0, input int abort_at);
    exp_t e;
    logic [3:0] cur, diff;
    int n, a;
    trace.delete();
    diff = tv - sv;
    n = int'(diff);
    cur = sh0;
    for (int l = 0; l < LOOPS; l++) begin
      e = '0; e.load = 1'b1; e.busy = 1'b1; e.done = (l > 0); e.d = sv; e.shadow = cur;
      trace.push_back(e);
      cur = sv;
      for (int i = 0; i < n; i++)
        for (int p = 0; p < presc; p++) begin
          e = '0; e.busy = 1'b1; e.d = sv; e.shadow = cur; e.en = (p == presc - 1);
          trace.push_back(e);
          if (e.en) cur = cur + 4'd1;
        end
      for (int h = 0; h < hold; h++) begin
        e = '0; e.busy = 1'b1; e.oe = 1'b1; e.d = sv; e.shadow = cur;
        trace.push_back(e);
      end
    end
    e = '0; e.done = 1'b1; e.d = sv; e.shadow = cur;
`ifdef CONTADOR_SECUENCIADOR_AUTORELOAD_EN
    e.load = 1'b1; e.busy = 1'b1;
`endif
    trace.push_back(e);
    a = abort_at;
`ifdef CONTADOR_SECUENCIADOR_AUTORELOAD_EN
    if (a < 1 || a > trace.size()) a = trace.size();
`endif
    if (a >= 1 && a <= trace.size()) begin
      while (trace.size() > a) void'(trace.pop_back());
      e = trace[a-1];
      e.load = 1'b0; e.en = 1'b0; e.oe = 1'b0; e.busy = 1'b0; e.done = 1'b0;
      trace.push_back(e);
    end
    eff_abort = a;
  endfunction

  task automatic run_seq(input logic [3:0] sv, input logic [3:0] tv,
                         input int a4_in, input int a1_in, input bit extra);
    int a4, a1, ncyc;
    exp_t e;
    build(4, 3, sv, tv, sh4, a4_in); q4 = trace; a4 = eff_abort;
    build(1, 3, sv, tv, sh1, a1_in); q1 = trace; a1 = eff_abort;
    ncyc = ((q4.size() > q1.size()) ? q4.size() : q1.size()) + 2;
    while (q4.size() < ncyc) begin
      e = q4[q4.size()-1]; e.load = 0; e.en = 0; e.oe = 0; e.busy = 0; e.done = 0;
      q4.push_back(e);
    end
    while (q1.size() < ncyc) begin
      e = q1[q1.size()-1]; e.load = 0; e.en = 0; e.oe = 0; e.busy = 0; e.done = 0;
      q1.push_back(e);
    end
    sh4 = q4[ncyc-1].shadow;
    sh1 = q1[ncyc-1].shadow;
    obs4.delete(); obs1.delete();
    @(negedge clk);
    bus4.start = 1'b1; bus4.start_val = sv; bus4.stop_val = tv;
    bus4.abort = 1'b0; bus1.abort = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      obs4.push_back(sample4());
      obs1.push_back(sample1());
      bus4.start     = extra && (c == 2);
      bus4.start_val = 4'($urandom);
      bus4.stop_val  = 4'($urandom);
      bus4.abort     = (c == a4);
      bus1.abort     = (c == a1);
    end
    bus4.start = 1'b0; bus4.abort = 1'b0; bus1.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.start = 1'b0; bus4.start_val = 4'd7; bus4.stop_val = 4'd9;
    bus4.abort = 1'b0; bus1.abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sample4() !== exp_t'(0)) $display("FAIL reset4 got %h exp 0", sample4()); else passes++;
    checks++;
    if (sample1() !== exp_t'(0)) $display("FAIL reset1 got %h exp 0", sample1()); else passes++;
    rst = 1'b0;
    // start and abort together in IDLE: nothing starts
    bus4.start = 1'b1; bus4.abort = 1'b1; bus1.abort = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0; bus4.abort = 1'b0; bus1.abort = 1'b0;
    checks++;
    if (sample4() !== exp_t'(0)) $display("FAIL start_abort_idle got %h exp 0", sample4()); else passes++;
  endtask

  task automatic test_basic();
    int n_en, n_oe, n_done;
    run_seq(4'd3, 4'd6, -1, -1, 1'b0);
    n_en = 0; n_oe = 0; n_done = 0;
    for (int i = 0; i < obs4.size(); i++) begin
      checks++;
      if (obs4[i] !== q4[i]) $display("FAIL basic4 cyc %0d got %h exp %h", i+1, obs4[i], q4[i]); else passes++;
      checks++;
      if (obs1[i] !== q1[i]) $display("FAIL basic1 cyc %0d got %h exp %h", i+1, obs1[i], q1[i]); else passes++;
      n_en += int'(obs4[i].en); n_oe += int'(obs4[i].oe); n_done += int'(obs4[i].done);
    end
`ifndef CONTADOR_SECUENCIADOR_AUTORELOAD_EN
    checks++;
    if (n_en != 3 || n_oe != 3 || n_done != 1)
      $display("FAIL basic_counts got en=%0d oe=%0d done=%0d exp 3/3/1", n_en, n_oe, n_done);
    else passes++;
`endif
  endtask

  task automatic test_equal();
    int n_en;
    run_seq(4'd9, 4'd9, -1, -1, 1'b0);
    n_en = 0;
    for (int i = 0; i < obs4.size(); i++) begin
      checks++;
      if (obs4[i] !== q4[i]) $display("FAIL equal4 cyc %0d got %h exp %h", i+1, obs4[i], q4[i]); else passes++;
      checks++;
      if (obs1[i] !== q1[i]) $display("FAIL equal1 cyc %0d got %h exp %h", i+1, obs1[i], q1[i]); else passes++;
      n_en += int'(obs4[i].en) + int'(obs1[i].en);
    end
    checks++;
    if (n_en != 0 || obs4[obs4.size()-1].shadow !== 4'd9)
      $display("FAIL equal_noen got en=%0d shadow=%0d exp 0/9", n_en, obs4[obs4.size()-1].shadow);
    else passes++;
  endtask

  task automatic test_wrap();
    run_seq(4'd14, 4'd2, -1, -1, 1'b0);
    for (int i = 0; i < obs1.size(); i++) begin
      checks++;
      if (obs1[i] !== q1[i]) $display("FAIL wrap1 cyc %0d got %h exp %h", i+1, obs1[i], q1[i]); else passes++;
      checks++;
      if (obs4[i] !== q4[i]) $display("FAIL wrap4 cyc %0d got %h exp %h", i+1, obs4[i], q4[i]); else passes++;
    end
    // PRESC=1: en high cycles 2..5, shadow 14,15,0,1 during them, then SHOW with 2
    checks++;
    if (!(obs1[1].en && obs1[2].en && obs1[3].en && obs1[4].en) || obs1[5].en || !obs1[5].oe ||
        obs1[5].shadow !== 4'd2)
      $display("FAIL wrap_en got en=%b%b%b%b%b oe=%b shadow=%0d exp 11110 1 2",
               obs1[1].en, obs1[2].en, obs1[3].en, obs1[4].en, obs1[5].en, obs1[5].oe, obs1[5].shadow);
    else passes++;
  endtask

  task automatic test_abort();
    // PRESC=4 en pulses in cycles 5, 9, 13; abort in cycle 14
    run_seq(4'd0, 4'd10, 14, -1, 1'b0);
    for (int i = 0; i < obs4.size(); i++) begin
      checks++;
      if (obs4[i] !== q4[i]) $display("FAIL abort4 cyc %0d got %h exp %h", i+1, obs4[i], q4[i]); else passes++;
      checks++;
      if (obs1[i] !== q1[i]) $display("FAIL abort1 cyc %0d got %h exp %h", i+1, obs1[i], q1[i]); else passes++;
    end
    checks++;
    if (obs4[14].busy || obs4[14].en || obs4[14].oe || obs4[14].done || obs4[14].shadow !== 4'd3)
      $display("FAIL abort_state got %h exp busy/en/oe/done 0 shadow 3", obs4[14]);
    else passes++;
  endtask

  task automatic test_busy_start();
    run_seq(4'd5, 4'd7, -1, -1, 1'b1);
    for (int i = 0; i < obs4.size(); i++) begin
      checks++;
      if (obs4[i] !== q4[i]) $display("FAIL busystart4 cyc %0d got %h exp %h", i+1, obs4[i], q4[i]); else passes++;
      checks++;
      if (obs1[i] !== q1[i]) $display("FAIL busystart1 cyc %0d got %h exp %h", i+1, obs1[i], q1[i]); else passes++;
    end
  endtask

  task automatic test_rst_show();
    bit seen;
    @(negedge clk);
    bus4.start = 1'b1; bus4.start_val = 4'd2; bus4.stop_val = 4'd3;
    @(negedge clk);
    bus4.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus4.oe) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) $display("FAIL rst_show_reach got oe=0 exp oe=1 within 40 cycles"); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (sample4() !== exp_t'(0)) $display("FAIL rst_show4 got %h exp 0", sample4()); else passes++;
    checks++;
    if (sample1() !== exp_t'(0)) $display("FAIL rst_show1 got %h exp 0", sample1()); else passes++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus4.done || bus4.busy) $display("FAIL rst_nodone got done=%b busy=%b exp 0/0", bus4.done, bus4.busy);
      else passes++;
    end
    sh4 = '0; sh1 = '0;
  endtask

  task automatic test_random();
    int a4, a1;
    logic [3:0] sv, tv;
    for (int it = 0; it < 8; it++) begin
      sv = 4'($urandom); tv = 4'($urandom);
      a4 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
      a1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : -1;
      run_seq(sv, tv, a4, a1, 1'b0);
      for (int i = 0; i < obs4.size(); i++) begin
        checks++;
        if (obs4[i] !== q4[i])
          $display("FAIL rand4 it %0d sv %0d tv %0d cyc %0d got %h exp %h", it, sv, tv, i+1, obs4[i], q4[i]);
        else passes++;
        checks++;
        if (obs1[i] !== q1[i])
          $display("FAIL rand1 it %0d sv %0d tv %0d cyc %0d got %h exp %h", it, sv, tv, i+1, obs1[i], q1[i]);
        else passes++;
      end
    end
  endtask

`ifdef CONTADOR_SECUENCIADOR_AUTORELOAD_EN
  task automatic test_autoreload();
    int n_load;
    run_seq(4'd1, 4'd3, -1, -1, 1'b0);
    n_load = 0;
    for (int i = 0; i < obs4.size(); i++) begin
      checks++;
      if (obs4[i] !== q4[i]) $display("FAIL reload4 cyc %0d got %h exp %h", i+1, obs4[i], q4[i]); else passes++;
      n_load += int'(obs4[i].load && obs4[i].done && obs4[i].busy && obs4[i].d == 4'd1);
    end
    checks++;
    if (n_load != 2) $display("FAIL reload_count got %0d exp 2", n_load); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_wrap();
    test_abort();
    test_busy_start();
    test_rst_show();
    test_random();
`ifdef CONTADOR_SECUENCIADOR_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
